traffic_btn_cond: RTL and testbench
===================================

Name: traffic_btn_cond

Overview:
- Input conditioner upstream of the intersection light controller.
- Takes the two raw, asynchronous, active-low push buttons (timing-mode select and hold/pause request).
- Synchronizes and debounces them, then turns accepted presses into the controller's inputs:
  - a registered 2-bit timing mode;
  - a hold-request level.
- Emits a single-cycle change strobe for each of these outputs.

Parameters:
- DEB_CYCLES, 16: consecutive stable synchronized samples required to accept a level change. Minimum 2.
- LONG_CYCLES, 200: cycles the debounced mode button must stay pressed after acceptance to force mode to 00. Must be greater than DEB_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- btn_mode_n  in  1  raw mode button, active-low, asynchronous, bouncy
- btn_hold_n  in  1  raw hold button, active-low, asynchronous, bouncy
- mode  out  2  timing mode to controller: 00 short, 01 medium, 10 long; 11 never driven
- mode_chg  out  1  one-cycle strobe; mode was just updated
- hold_req  out  1  hold/pause level to controller; toggles per accepted hold press
- hold_chg  out  1  one-cycle strobe; hold_req just toggled
- mode_db  out  1  debounced mode button, active-high (1 = pressed)
- hold_db  out  1  debounced hold button, active-high

Behaviour:
- Reset is synchronous, active-low, clock clk. While rst_n=0, all of the following are 0 on every edge:
  - mode, mode_chg, hold_req, hold_chg, mode_db, hold_db;
  - synchronizer flops, which hold the inverted value, so 0 = released;
  - debounce counters and the long-press counter.
- Synchronizer, per channel: two flops, input inverted to active-high.
  - The raw value sampled at edge 0 appears at the second flop after edge 1.
- Debounce, per channel: counter 0..DEB_CYCLES-1.
  - If sync equals db: counter is set to 0.
  - Else, if counter = DEB_CYCLES-1: db takes the sync value and counter is set to 0.
  - Else: counter increments.
- Result: a clean raw transition first sampled at edge 0 updates db at edge DEB_CYCLES+1.
- A bounce that reverts before acceptance clears the counter and produces no output change.
- Accepted mode press (mode_db rising):
  - On the same edge, mode advances 00→01→10→00.
  - mode_chg is 1 for exactly the following cycle.
- Accepted hold press (hold_db rising):
  - On the same edge, hold_req inverts.
  - hold_chg is 1 for exactly the following cycle.
- Releases (db falling) never change mode or hold_req.
- Long press:
  - The long counter clears on the mode_db rising edge and increments each edge while mode_db=1.
  - At the edge LONG_CYCLES edges after acceptance, mode is forced to 00 and mode_chg pulses once.
  - The pulse occurs even if mode was already 00.
  - This fires at most once per press; the counter saturates until mode_db falls.
- Total latency with DEB_CYCLES=16: a clean press first sampled at edge 0 changes mode at edge 17.
- Both channels are fully independent. Simultaneous accepted presses produce both strobes in the same cycle.
- Strobes are registered and never longer than one cycle. Consecutive accepted presses are at least 2·DEB_CYCLES cycles apart, so strobes never merge.
- Reset mid-operation:
  - All state clears immediately and any pending count is discarded.
  - A button still held when rst_n rises is treated as a new press: accepted at edge DEB_CYCLES+1 after the first post-reset edge.
- mode never takes the value 11.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=10):
- Clean press: btn_mode_n 1→0 sampled at edge 0, held → mode_db=1 and mode 00→01 at edge 5; mode_chg=1 only in the cycle after edge 5; hold outputs unchanged.
- Bounce rejection: btn_mode_n low for 3 cycles, high 2, low 2, then high → mode_db, mode and mode_chg never change.
- Mode wrap: three clean press/release pairs, each 8 cycles low and 8 high → mode sequence 01, 10, 00; exactly three mode_chg pulses.
- Long press: mode=10, then btn_mode_n held low 30 cycles → mode=00 at acceptance (wrap, strobe); still 00 at edge 15 with a second strobe; no further strobes until release and re-press.
- Hold toggle and simultaneity: both buttons pressed on the same edge → mode_chg and hold_chg high in the same cycle; hold_req 0→1; a second hold press → hold_req 1→0.
- Reset mid-count: hold button low for 3 cycles, then rst_n=0 for 2 cycles with the button still low → all outputs 0; after release of reset, hold_req=1 at edge 5 counted from the first post-reset edge.

Source files
------------

// File: rtl/traffic_btn_cond.sv
// Button conditioner for the intersection light controller: synchronizes and
// debounces the raw mode/hold buttons and turns accepted presses into mode/hold levels.

module traffic_btn_cond_deb #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw_n,
    output logic o_db,
    output logic o_rise
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_expire;

    assign w_diff   = (r_sync2 != r_db);
    assign w_expire = w_diff && (r_cnt == CW'(DEB_CYCLES - 1));

    // High when db is about to rise on this edge, so the consumer can act on the same edge.
    assign o_rise = w_expire && r_sync2;
    assign o_db   = r_db;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= ~i_raw_n;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_expire) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

module traffic_btn_cond #(
    parameter int DEB_CYCLES  = 16,
    parameter int LONG_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn_mode_n,
    input  logic       i_btn_hold_n,
    output logic [1:0] o_mode,
    output logic       o_mode_chg,
    output logic       o_hold_req,
    output logic       o_hold_chg,
    output logic       o_mode_db,
    output logic       o_hold_db
);
    localparam int LW = $clog2(LONG_CYCLES + 1);

    logic          w_mode_db;
    logic          w_mode_rise;
    logic          w_hold_db;
    logic          w_hold_rise;
    logic [1:0]    w_mode_next;
    logic          w_long_fire;

    logic [1:0]    r_mode;
    logic          r_mode_chg;
    logic          r_hold_req;
    logic          r_hold_chg;
    logic [LW-1:0] r_long_cnt;

    traffic_btn_cond_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw_n (i_btn_mode_n),
        .o_db    (w_mode_db),
        .o_rise  (w_mode_rise)
    );

    traffic_btn_cond_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw_n (i_btn_hold_n),
        .o_db    (w_hold_db),
        .o_rise  (w_hold_rise)
    );

    always_comb begin
        w_mode_next = 2'b00;
        case (r_mode)
            2'b00:   w_mode_next = 2'b01;
            2'b01:   w_mode_next = 2'b10;
            default: w_mode_next = 2'b00;
        endcase
    end

    // Counter parks at LONG_CYCLES after firing, so one held press forces 00 only once.
    assign w_long_fire = w_mode_db && (r_long_cnt == LW'(LONG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode     <= 2'b00;
            r_mode_chg <= 1'b0;
            r_long_cnt <= '0;
        end else begin
            r_mode_chg <= 1'b0;
            if (w_mode_rise) begin
                r_mode     <= w_mode_next;
                r_mode_chg <= 1'b1;
                r_long_cnt <= '0;
            end else if (w_long_fire) begin
                r_mode     <= 2'b00;
                r_mode_chg <= 1'b1;
                r_long_cnt <= LW'(LONG_CYCLES);
            end else if (w_mode_db) begin
                if (r_long_cnt != LW'(LONG_CYCLES))
                    r_long_cnt <= r_long_cnt + 1'b1;
            end else begin
                r_long_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_req <= 1'b0;
            r_hold_chg <= 1'b0;
        end else begin
            r_hold_chg <= 1'b0;
            if (w_hold_rise) begin
                r_hold_req <= ~r_hold_req;
                r_hold_chg <= 1'b1;
            end
        end
    end

    assign o_mode     = r_mode;
    assign o_mode_chg = r_mode_chg;
    assign o_hold_req = r_hold_req;
    assign o_hold_chg = r_hold_chg;
    assign o_mode_db  = w_mode_db;
    assign o_hold_db  = w_hold_db;
endmodule

// File: tb/tb_traffic_btn_cond.sv
// Directed vector table plus hand sequences for traffic_btn_cond (DEB_CYCLES=4, LONG_CYCLES=10).

module tb_traffic_btn_cond;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode_n;
    logic       btn_hold_n;
    logic [1:0] mode;
    logic       mode_chg, hold_req, hold_chg, mode_db, hold_db;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       m_n;
        logic       h_n;
        logic [1:0] mode;
        logic       mc;
        logic       hr;
        logic       hc;
        logic       mdb;
        logic       hdb;
    } vec_t;

    vec_t vecs[$];

    traffic_btn_cond #(.DEB_CYCLES(4), .LONG_CYCLES(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_btn_mode_n (btn_mode_n),
        .i_btn_hold_n (btn_hold_n),
        .o_mode       (mode),
        .o_mode_chg   (mode_chg),
        .o_hold_req   (hold_req),
        .o_hold_chg   (hold_chg),
        .o_mode_db    (mode_db),
        .o_hold_db    (hold_db)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic r, input logic m, input logic h, input logic [1:0] md,
                        input logic mc, input logic hr, input logic hc,
                        input logic mdb, input logic hdb);
        vec_t v;
        v.rst_n = r; v.m_n = m; v.h_n = h; v.mode = md; v.mc = mc;
        v.hr = hr; v.hc = hc; v.mdb = mdb; v.hdb = hdb;
        vecs.push_back(v);
    endtask

    // One press of the mode button (low cycles) then release (high cycles); returns strobe count.
    task automatic mode_press(input int lo, input int hi, output int pulses);
        pulses = 0;
        for (int c = 0; c < lo + hi; c++) begin
            btn_mode_n = (c < lo) ? 1'b0 : 1'b1;
            step();
            if (mode_chg) pulses++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn_mode_n = 1'b1; btn_hold_n = 1'b1;
        step(); step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [12:0] bounce;
        int          p;
        int          total;
        logic [1:0]  wrap_exp [3];

        rst_n = 1'b0; btn_mode_n = 1'b1; btn_hold_n = 1'b1;

        // reset
        addv(0,1,1, 2'd0,0,0,0,0,0);
        addv(0,1,1, 2'd0,0,0,0,0,0);
        // clean mode press, accepted at edge 5
        for (int e = 0; e < 5; e++) addv(1,0,1, 2'd0,0,0,0,0,0);
        addv(1,0,1, 2'd1,1,0,0,1,0);
        for (int e = 6; e < 8; e++)  addv(1,0,1, 2'd1,0,0,0,1,0);
        for (int e = 8; e < 13; e++) addv(1,1,1, 2'd1,0,0,0,1,0);
        for (int e = 13; e < 18; e++) addv(1,1,1, 2'd1,0,0,0,0,0);
        // bounce: low 3, high 2, low 2, then high
        bounce = 13'b1111110011000;
        for (int e = 0; e < 13; e++) addv(1,bounce[e],1, 2'd1,0,0,0,0,0);
        // simultaneous mode + hold press
        for (int e = 0; e < 5; e++) addv(1,0,0, 2'd1,0,0,0,0,0);
        addv(1,0,0, 2'd2,1,1,1,1,1);
        for (int e = 6; e < 8; e++)  addv(1,0,0, 2'd2,0,1,0,1,1);
        for (int e = 8; e < 13; e++) addv(1,1,1, 2'd2,0,1,0,1,1);
        for (int e = 13; e < 18; e++) addv(1,1,1, 2'd2,0,1,0,0,0);
        // second hold press toggles back
        for (int e = 0; e < 5; e++) addv(1,1,0, 2'd2,0,1,0,0,0);
        addv(1,1,0, 2'd2,0,0,1,0,1);
        for (int e = 6; e < 8; e++)  addv(1,1,0, 2'd2,0,0,0,0,1);
        for (int e = 8; e < 13; e++) addv(1,1,1, 2'd2,0,0,0,0,1);
        for (int e = 13; e < 18; e++) addv(1,1,1, 2'd2,0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; btn_mode_n = vecs[i].m_n; btn_hold_n = vecs[i].h_n;
            step();
            chk($sformatf("vec%0d mode", i),     mode,     vecs[i].mode);
            chk($sformatf("vec%0d mode_chg", i), mode_chg, vecs[i].mc);
            chk($sformatf("vec%0d hold_req", i), hold_req, vecs[i].hr);
            chk($sformatf("vec%0d hold_chg", i), hold_chg, vecs[i].hc);
            chk($sformatf("vec%0d mode_db", i),  mode_db,  vecs[i].mdb);
            chk($sformatf("vec%0d hold_db", i),  hold_db,  vecs[i].hdb);
        end

        // mode wrap 01 -> 10 -> 00
        do_reset();
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd0;
        total = 0;
        for (int k = 0; k < 3; k++) begin
            mode_press(8, 8, p);
            total += p;
            chk($sformatf("wrap%0d mode", k), mode, wrap_exp[k]);
            chk($sformatf("wrap%0d pulses", k), p, 1);
        end
        chk("wrap total pulses", total, 3);

        // long press from mode 10
        mode_press(8, 8, p);
        mode_press(8, 8, p);
        chk("long pre mode", mode, 2);
        total = 0;
        for (int e = 0; e < 30; e++) begin
            btn_mode_n = 1'b0;
            step();
            if (mode_chg) total++;
            if (e == 5) begin
                chk("long accept mode", mode, 0);
                chk("long accept strobe", mode_chg, 1);
            end
            if (e == 14) chk("long pre-fire strobe", mode_chg, 0);
            if (e == 15) begin
                chk("long fire mode", mode, 0);
                chk("long fire strobe", mode_chg, 1);
            end
        end
        chk("long held pulses", total, 2);
        mode_press(0, 16, p);
        chk("long release pulses", p, 0);
        chk("long release mode", mode, 0);
        mode_press(8, 8, p);
        chk("repress mode", mode, 1);
        chk("repress pulses", p, 1);

        // reset in the middle of a hold debounce count
        btn_hold_n = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        step(); step();
        chk("rst mode", mode, 0);
        chk("rst mode_chg", mode_chg, 0);
        chk("rst hold_req", hold_req, 0);
        chk("rst hold_chg", hold_chg, 0);
        chk("rst mode_db", mode_db, 0);
        chk("rst hold_db", hold_db, 0);
        rst_n = 1'b1;
        for (int e = 0; e < 7; e++) begin
            step();
            if (e == 4) begin
                chk("post-rst edge4 hold_req", hold_req, 0);
                chk("post-rst edge4 hold_db", hold_db, 0);
            end
            if (e == 5) begin
                chk("post-rst edge5 hold_req", hold_req, 1);
                chk("post-rst edge5 hold_chg", hold_chg, 1);
            end
            if (e == 6) chk("post-rst edge6 hold_chg", hold_chg, 0);
        end
        btn_hold_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
